// File: rtl/dll_code_ctrl.sv
// DLL delay-code controller: steps a 4-bit delay-line select code from
// phase-detector votes, detects lock and loss of lock. Optional build macro:
// DLL_CTRL_MAJORITY_EN (moves need two agreeing consecutive samples).
module dll_code_ctrl #(
  parameter int unsigned INIT_CODE  = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned LOSS_CNT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pd_valid,
  input  logic       pd_up,
  input  logic       pd_dn,
  output logic [3:0] q,
  output logic       dec_rst_n,
  output logic [1:0] state,
  output logic       locked,
  output logic       lock_lost,
  output logic       sat_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MV_HOLD = 2'd0,
    MV_UP   = 2'd1,
    MV_DN   = 2'd2
  } move_t;

  localparam logic [3:0] LP_INIT   = INIT_CODE[3:0];
  localparam logic [7:0] LP_SETTLE = SETTLE_CYC[7:0];
  localparam logic [3:0] LP_LOCK   = LOCK_CNT[3:0];
  localparam logic [3:0] LP_LOSS   = LOSS_CNT[3:0];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_settle_cnt;
  logic [3:0] r_q;
  logic [3:0] r_rev_cnt;
  logic [3:0] r_run_cnt;
  logic       r_last_vld;
  logic       r_last_up;
  logic       r_locked;
  logic       r_lock_lost;
  logic       r_sat_err;

  move_t      w_raw_move;
  move_t      w_move;
  logic       w_fire;
  logic       w_is_move;
  logic       w_is_up;
  logic       w_at_limit;
  logic       w_reversal;
  logic       w_same_dir;
  logic [3:0] w_rev_nxt;
  logic [3:0] w_run_nxt;
  logic       w_lose;
  logic       w_gain;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  // NOTE: default assignment first so no path leaves w_state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (r_settle_cnt <= 8'd1) w_state_nxt = ST_SAMPLE;
        ST_SAMPLE: if (pd_valid) w_state_nxt = ST_SETTLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    state     = r_state;
    dec_rst_n = (r_state != ST_IDLE);
  end

  assign q         = r_q;
  assign locked    = r_locked;
  assign lock_lost = r_lock_lost;
  assign sat_err   = r_sat_err;

  // ---------------------------------------------------------------------------
  // Phase-detector decode and optional majority filter
  // ---------------------------------------------------------------------------
  always_comb begin
    w_raw_move = MV_HOLD;
    if (pd_up && !pd_dn)      w_raw_move = MV_UP;
    else if (pd_dn && !pd_up) w_raw_move = MV_DN;
  end

  assign w_fire = en && (r_state == ST_SAMPLE) && pd_valid;

`ifdef DLL_CTRL_MAJORITY_EN
  move_t r_maj_dir;
  logic  r_maj_vld;

  // A vote is applied only when it repeats the recorded one; any applied,
  // disagreeing or HOLD vote empties the record.
  always_comb begin
    w_move = MV_HOLD;
    if (w_raw_move != MV_HOLD && r_maj_vld && r_maj_dir == w_raw_move)
      w_move = w_raw_move;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_maj_vld <= 1'b0;
      r_maj_dir <= MV_HOLD;
    end else if (w_fire) begin
      if (w_raw_move != MV_HOLD && !r_maj_vld) begin
        r_maj_vld <= 1'b1;
        r_maj_dir <= w_raw_move;
      end else begin
        r_maj_vld <= 1'b0;
        r_maj_dir <= MV_HOLD;
      end
    end
  end
`else
  assign w_move = w_raw_move;
`endif

  // ---------------------------------------------------------------------------
  // Move classification and lock bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    w_is_move  = w_fire && (w_move != MV_HOLD);
    w_is_up    = (w_move == MV_UP);
    w_at_limit = w_is_up ? (r_q == 4'hF) : (r_q == 4'h0);
    w_reversal = r_last_vld && (r_last_up != w_is_up);
    w_same_dir = r_last_vld && (r_last_up == w_is_up);

    w_rev_nxt = r_rev_cnt;
    if (w_reversal)
      w_rev_nxt = (r_rev_cnt == 4'hF) ? r_rev_cnt : r_rev_cnt + 4'd1;
    else if (w_same_dir)
      w_rev_nxt = 4'd0;

    // Run length counts the moves in the current direction, the reversing
    // move itself included, so a reversal restarts it at one.
    w_run_nxt = 4'd0;
    if (r_locked) begin
      if (w_reversal)
        w_run_nxt = 4'd1;
      else
        w_run_nxt = (r_run_cnt == 4'hF) ? r_run_cnt : r_run_cnt + 4'd1;
    end

    w_lose = r_locked && (w_run_nxt >= LP_LOSS);
    w_gain = !r_locked && (w_rev_nxt >= LP_LOCK);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q          <= LP_INIT;
      r_settle_cnt <= 8'd0;
      r_rev_cnt    <= 4'd0;
      r_run_cnt    <= 4'd0;
      r_last_vld   <= 1'b0;
      r_last_up    <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_sat_err    <= 1'b0;
    end else if (!en) begin
      // Disable parks the loop: code is frozen, all lock history dropped.
      r_settle_cnt <= 8'd0;
      r_rev_cnt    <= 4'd0;
      r_run_cnt    <= 4'd0;
      r_last_vld   <= 1'b0;
      r_last_up    <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_sat_err    <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_q          <= LP_INIT;
          r_settle_cnt <= LP_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle_cnt != 8'd0) r_settle_cnt <= r_settle_cnt - 8'd1;
        end
        ST_SAMPLE: begin
          if (pd_valid) r_settle_cnt <= LP_SETTLE;
          if (w_is_move) begin
            if (w_at_limit)   r_sat_err <= 1'b1;
            else if (w_is_up) r_q <= r_q + 4'd1;
            else              r_q <= r_q - 4'd1;
            r_last_vld <= 1'b1;
            r_last_up  <= w_is_up;
            if (w_lose) begin
              r_locked    <= 1'b0;
              r_lock_lost <= 1'b1;
              r_rev_cnt   <= 4'd0;
              r_run_cnt   <= 4'd0;
            end else begin
              r_rev_cnt <= w_rev_nxt;
              r_run_cnt <= w_run_nxt;
              if (w_gain) r_locked <= 1'b1;
            end
          end
        end
        default: r_settle_cnt <= 8'd0;
      endcase
    end
  end

endmodule
